// File: rtl/t5_lsu.sv
// t5_lsu: load/store unit bridging the X stage to a Wishbone-style data bus.
// Issues one bus cycle per aligned load/store, stalls the pipeline until the
// ack arrives and buffers load data when the pipeline itself is stalled.
//
// Handshake: the bus request (dwb_stb/dwb_cyc with adr/sel/dto/wre) is raised
// the cycle after an aligned memop is seen in IDLE. It is held stable until
// the first cycle in which dwb_ack is high, and it drops on the next edge.
// The pipeline advances on any edge where sena is high and lhold is low.
module t5_lsu #(
    parameter int XLEN = 32
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic            xvld,
    input  logic [6:2]      xopc,
    input  logic [14:12]    xfn3,
    input  logic [XLEN-1:0] xadr,
    input  logic [XLEN-1:0] xrs2,
    output logic [XLEN-1:0] dwb_adr,
    output logic [XLEN-1:0] dwb_dto,
    output logic [3:0]      dwb_sel,
    output logic            dwb_stb,
    output logic            dwb_cyc,
    output logic            dwb_wre,
    input  logic            dwb_ack,
    input  logic [XLEN-1:0] dwb_dti,
    output logic [3:0]      xsel,
    output logic            xstb,
    output logic            xwre,
    output logic [XLEN-1:0] ldat,
    output logic            lhold,
    output logic            xmis,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic            is_load;
    logic            is_store;
    logic            memop;
    logic            align_ok;
    logic [3:0]      sel_c;
    logic [XLEN-1:0] dto_c;
    logic [XLEN-1:0] lbuf;
    logic            unused_sign;

    // The unsigned flag is consumed by writeback, not by the bus side.
    assign unused_sign = xfn3[14];
    assign dbg_state   = state;

    // Decode the X-stage instruction: op kind, alignment, lanes, store data.
    always_comb begin
        is_load  = (xopc == 5'b00000);
        is_store = (xopc == 5'b01000);
        memop    = xvld & (is_load | is_store);
        align_ok = 1'b0;
        sel_c    = 4'h0;
        dto_c    = xrs2;
        case (xfn3[13:12])
            2'b00: begin
                align_ok = 1'b1;
                sel_c    = 4'b0001 << xadr[1:0];
                dto_c    = {4{xrs2[7:0]}};
            end
            2'b01: begin
                align_ok = ~xadr[0];
                sel_c    = xadr[1] ? 4'hC : 4'h3;
                dto_c    = {2{xrs2[15:0]}};
            end
            2'b10: begin
                align_ok = (xadr[1:0] == 2'b00);
                sel_c    = 4'hF;
                dto_c    = xrs2;
            end
            default: begin
                align_ok = 1'b0;
                sel_c    = 4'h0;
                dto_c    = xrs2;
            end
        endcase
    end

    // Stall, misalignment flag and load data return toward writeback.
    always_comb begin
        lhold = ((state == S_IDLE) & memop & align_ok) | ((state == S_REQ) & ~dwb_ack);
        xmis  = (state == S_IDLE) & memop & ~align_ok;
        ldat  = ((state == S_REQ) && dwb_ack) ? dwb_dti : lbuf;
    end

    // Transaction FSM with registered bus and writeback-side outputs.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state   <= S_IDLE;
            dwb_adr <= '0;
            dwb_dto <= '0;
            dwb_sel <= 4'h0;
            dwb_stb <= 1'b0;
            dwb_cyc <= 1'b0;
            dwb_wre <= 1'b0;
            xsel    <= 4'h0;
            xstb    <= 1'b0;
            xwre    <= 1'b0;
            lbuf    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memop && align_ok) begin
                        state   <= S_REQ;
                        dwb_adr <= {xadr[XLEN-1:2], 2'b00};
                        dwb_dto <= dto_c;
                        dwb_sel <= sel_c;
                        dwb_wre <= is_store;
                        dwb_stb <= 1'b1;
                        dwb_cyc <= 1'b1;
                        xsel    <= sel_c;
                        xwre    <= is_store;
                        xstb    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (dwb_ack) begin
                        dwb_stb <= 1'b0;
                        dwb_cyc <= 1'b0;
                        if (sena) begin
                            state <= S_IDLE;
                            xstb  <= 1'b0;
                            xsel  <= 4'h0;
                            xwre  <= 1'b0;
                        end else begin
                            // Pipeline is frozen: keep the data until it advances.
                            state <= S_DONE;
                            lbuf  <= dwb_dti;
                        end
                    end
                end
                S_DONE: begin
                    if (sena) begin
                        state <= S_IDLE;
                        xstb  <= 1'b0;
                        xsel  <= 4'h0;
                        xwre  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t5_lsu.sv
// tb_t5_lsu: scoreboard bench for t5_lsu. The driver acts as the pipeline
// and the bus slave; a monitor matches every bus cycle against a queue of
// transactions predicted from the address/width/data rules.
module tb_t5_lsu;

    localparam int EW = 32 + 4 + 32 + 1;

    logic        sclk = 1'b0;
    logic        srst;
    logic        sena;
    logic        xvld;
    logic [4:0]  xopc;
    logic [2:0]  xfn3;
    logic [31:0] xadr;
    logic [31:0] xrs2;
    logic [31:0] dwb_adr;
    logic [31:0] dwb_dto;
    logic [3:0]  dwb_sel;
    logic        dwb_stb;
    logic        dwb_cyc;
    logic        dwb_wre;
    logic        dwb_ack;
    logic [31:0] dwb_dti;
    logic [3:0]  xsel;
    logic        xstb;
    logic        xwre;
    logic [31:0] ldat;
    logic        lhold;
    logic        xmis;
    logic [1:0]  dbg_state;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   ldat_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    t5_lsu #(.XLEN(32)) dut (
        .sclk(sclk), .srst(srst), .sena(sena), .xvld(xvld), .xopc(xopc),
        .xfn3(xfn3), .xadr(xadr), .xrs2(xrs2), .dwb_adr(dwb_adr),
        .dwb_dto(dwb_dto), .dwb_sel(dwb_sel), .dwb_stb(dwb_stb),
        .dwb_cyc(dwb_cyc), .dwb_wre(dwb_wre), .dwb_ack(dwb_ack),
        .dwb_dti(dwb_dti), .xsel(xsel), .xstb(xstb), .xwre(xwre),
        .ldat(ldat), .lhold(lhold), .xmis(xmis), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 sclk = ~sclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    function automatic bit is_aligned(input logic [2:0] fn3, input logic [31:0] adr);
        int sz;
        sz = 1 << int'(fn3[1:0]);
        return (fn3[1:0] != 2'b11) && ((int'(adr[1:0]) % sz) == 0);
    endfunction

    // Expected bus transaction: word address, lanes touched, replicated data, write flag.
    function automatic logic [EW-1:0] model_bus(input logic [4:0] opc, input logic [2:0] fn3,
                                                input logic [31:0] adr, input logic [31:0] rs2);
        int          sz;
        int          off;
        logic [3:0]  sel;
        logic [31:0] dto;
        sz  = 1 << int'(fn3[1:0]);
        off = int'(adr[1:0]);
        sel = 4'h0;
        dto = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + sz) sel[b] = 1'b1;
            dto[8*b +: 8] = 8'(rs2 >> (8 * (b % sz)));
        end
        return {adr & 32'hFFFF_FFFC, sel, dto, (opc == 5'b01000)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic          stb_seen = 1'b0;
    logic [EW-1:0] cur;

    always @(negedge sclk) begin
        logic [EW-1:0] e;
        logic [31:0]   ld;
        if (dwb_stb) begin
            if (!stb_seen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bus_cycle", 64'(exp_q.size()), 64'd1);
                    cur = {dwb_adr, dwb_sel, dwb_dto, dwb_wre};
                end else begin
                    e = exp_q.pop_front();
                    cur = e;
                    chk("dwb_adr", 64'(dwb_adr), 64'(e[68:37]));
                    chk("dwb_sel", 64'(dwb_sel), 64'(e[36:33]));
                    chk("dwb_dto", 64'(dwb_dto), 64'(e[32:1]));
                    chk("dwb_wre", 64'(dwb_wre), 64'(e[0]));
                    chk("dwb_cyc", 64'(dwb_cyc), 64'd1);
                    chk("xsel",    64'(xsel),    64'(e[36:33]));
                    chk("xwre",    64'(xwre),    64'(e[0]));
                    chk("xstb",    64'(xstb),    64'd1);
                end
            end else begin
                chk("bus_stable_adr", 64'(dwb_adr), 64'(cur[68:37]));
                chk("bus_stable_rest", 64'({dwb_sel, dwb_dto, dwb_wre}), 64'(cur[36:0]));
                chk("cyc_stable", 64'(dwb_cyc), 64'd1);
            end
            if (dwb_ack && !dwb_wre) begin
                if (ldat_q.size() == 0) begin
                    chk("unexpected_load_ack", 64'(ldat_q.size()), 64'd1);
                end else begin
                    ld = ldat_q.pop_front();
                    chk("ldat_ack", 64'(ldat), 64'(ld));
                end
            end
        end
        stb_seen = dwb_stb;
    end

    // ---------------- driver ----------------
    // Presents one instruction in X right after a clock edge with the FSM idle.
    task automatic run_op(input logic vld, input logic [4:0] opc, input logic [2:0] fn3,
                          input logic [31:0] adr, input logic [31:0] rs2,
                          input logic [31:0] dti, input int nwait, input int nstall);
        bit mem;
        bit ok;
        int hc;
        xvld = vld; xopc = opc; xfn3 = fn3; xadr = adr; xrs2 = rs2;
        sena = 1'b1; dwb_ack = 1'b0;
        mem = vld && (opc == 5'b00000 || opc == 5'b01000);
        ok  = is_aligned(fn3, adr);
        if (!mem || !ok) begin
            @(negedge sclk);
            chk("xmis", 64'(xmis), 64'(mem && !ok));
            chk("lhold_nobus", 64'(lhold), 64'd0);
            chk("stb_nobus", 64'(dwb_stb), 64'd0);
            step();
            xvld = 1'b0;
            @(negedge sclk);
            chk("stb_after_nobus", 64'(dwb_stb), 64'd0);
            chk("xstb_after_nobus", 64'(xstb), 64'd0);
            step();
            return;
        end
        exp_q.push_back(model_bus(opc, fn3, adr, rs2));
        @(negedge sclk);
        chk("stb_gap", 64'(dwb_stb), 64'd0);
        chk("lhold_idle", 64'(lhold), 64'd1);
        chk("xmis_ok", 64'(xmis), 64'd0);
        hc = 1;
        step();
        for (int w = 0; w < nwait; w++) begin
            @(negedge sclk);
            chk("lhold_wait", 64'(lhold), 64'd1);
            hc++;
            step();
        end
        dwb_ack = 1'b1;
        dwb_dti = dti;
        sena    = (nstall == 0);
        if (opc == 5'b00000) ldat_q.push_back(dti);
        @(negedge sclk);
        chk("stb_req", 64'(dwb_stb), 64'd1);
        chk("lhold_ack", 64'(lhold), 64'd0);
        chk("lhold_cycles", 64'(hc), 64'(nwait + 1));
        step();
        dwb_ack = 1'b0;
        dwb_dti = $urandom;
        if (nstall == 0) begin
            xvld = 1'b0;
            return;
        end
        for (int s = 0; s < nstall; s++) begin
            @(negedge sclk);
            if (opc == 5'b00000) chk("ldat_held", 64'(ldat), 64'(dti));
            chk("lhold_done", 64'(lhold), 64'd0);
            chk("stb_done", 64'(dwb_stb), 64'd0);
            chk("xstb_done", 64'(xstb), 64'd1);
            if (s == 0) dwb_ack = 1'b1;  // stray ack must be ignored
            step();
            dwb_ack = 1'b0;
        end
        sena = 1'b1;
        @(negedge sclk);
        chk("no_reissue", 64'(dwb_stb), 64'd0);
        step();
        xvld = 1'b0;
        @(negedge sclk);
        chk("stb_after_done", 64'(dwb_stb), 64'd0);
        chk("xstb_after_done", 64'(xstb), 64'd0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0]  opc_tab[3];
        logic [4:0]  r_opc;
        logic [31:0] r_adr;
        srst = 1'b1; sena = 1'b1; xvld = 1'b0; xopc = 5'h0; xfn3 = 3'h0;
        xadr = 32'h0; xrs2 = 32'h0; dwb_ack = 1'b0; dwb_dti = 32'h0;
        opc_tab[0] = 5'b00000; opc_tab[1] = 5'b01000; opc_tab[2] = 5'b00100;
        repeat (3) step();
        @(negedge sclk);
        chk("rst_stb",  64'(dwb_stb), 64'd0);
        chk("rst_cyc",  64'(dwb_cyc), 64'd0);
        chk("rst_wre",  64'(dwb_wre), 64'd0);
        chk("rst_sel",  64'(dwb_sel), 64'd0);
        chk("rst_adr",  64'(dwb_adr), 64'd0);
        chk("rst_dto",  64'(dwb_dto), 64'd0);
        chk("rst_xsel", 64'(xsel), 64'd0);
        chk("rst_xstb", 64'(xstb), 64'd0);
        chk("rst_xwre", 64'(xwre), 64'd0);
        chk("rst_lbuf", 64'(ldat), 64'd0);
        chk("rst_lhold", 64'(lhold), 64'd0);
        step();
        srst = 1'b0;

        // byte load, two wait states
        run_op(1'b1, 5'b00000, 3'b000, 32'h0000_1003, $urandom, 32'h55AA_1234, 2, 0);
        // half store on the upper half-word
        run_op(1'b1, 5'b01000, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 0);
        // misaligned word, illegal width
        run_op(1'b1, 5'b00000, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
        run_op(1'b1, 5'b00000, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
        // ack while the pipeline is stalled
        run_op(1'b1, 5'b00000, 3'b010, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 1, 3);
        // back-to-back load then store
        run_op(1'b1, 5'b00000, 3'b110, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 0, 0);
        run_op(1'b1, 5'b01000, 3'b000, 32'h0000_6001, 32'h0000_00A5, 32'h0, 1, 0);
        // non-memory op and invalid slot
        run_op(1'b1, 5'b00100, 3'b010, 32'h0000_7000, 32'h0, 32'h0, 0, 0);
        run_op(1'b0, 5'b00000, 3'b010, 32'h0000_7000, 32'h0, 32'h0, 0, 0);

        // reset in the middle of a request
        xvld = 1'b1; xopc = 5'b01000; xfn3 = 3'b010; xadr = 32'h0000_8000;
        xrs2 = 32'h0BAD_F00D; sena = 1'b1; dwb_ack = 1'b0;
        exp_q.push_back(model_bus(5'b01000, 3'b010, 32'h0000_8000, 32'h0BAD_F00D));
        step();
        xvld = 1'b0;
        @(negedge sclk);
        chk("rst_mid_stb_before", 64'(dwb_stb), 64'd1);
        step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        @(negedge sclk);
        chk("rst_mid_stb", 64'(dwb_stb), 64'd0);
        chk("rst_mid_cyc", 64'(dwb_cyc), 64'd0);
        chk("rst_mid_xstb", 64'(xstb), 64'd0);
        chk("rst_mid_lbuf", 64'(ldat), 64'd0);
        step();
        dwb_ack = 1'b1;
        @(negedge sclk);
        chk("late_ack_lhold", 64'(lhold), 64'd0);
        step();
        dwb_ack = 1'b0;
        @(negedge sclk);
        chk("late_ack_stb", 64'(dwb_stb), 64'd0);
        chk("late_ack_xstb", 64'(xstb), 64'd0);
        step();

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            r_opc = opc_tab[$urandom_range(0, 2)];
            r_adr = $urandom;
            if ($urandom_range(0, 3) != 0) r_adr[1:0] = 2'b00;
            run_op(($urandom_range(0, 7) != 0), r_opc, 3'($urandom_range(0, 7)), r_adr,
                   $urandom, $urandom, $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        repeat (2) step();
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("ldat_q_drained", 64'(ldat_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
